// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle sequencer: state encodings, PC source
// selects and the legal range of the memory timeout parameter.
package seq_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_JMP = 2'b01;
    localparam logic [1:0] PC_BR  = 2'b10;
    localparam logic [1:0] PC_REG = 2'b11;

    localparam int TIMEOUT_MIN = 1;
    localparam int TIMEOUT_MAX = 255;
    localparam int TIMEOUT_W   = 8;

    function automatic bit timeout_in_range(input int t);
        return (t >= TIMEOUT_MIN) && (t <= TIMEOUT_MAX);
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Counts consecutive cycles a memory request waits without an ack; expired is
// raised combinationally on the LIMIT-th such cycle.
module seq_timeout_counter
    import seq_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    logic [TIMEOUT_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= r_count + TIMEOUT_W'(1);
        end
    end

    assign expired = run && (r_count == TIMEOUT_W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 16-bit core (fetch/decode/exec/mem/wb).
// Define SEQ_PERF_CNT_EN to add the cycle_cnt / instret performance counters.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dec_halt,
    input  logic             dec_jump,
    input  logic             dec_jr,
    input  logic             dec_jlink,
    input  logic             dec_branch,
    input  logic             dec_blt,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_wb,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel_pc,
    output logic             ir_en,
    output logic             ab_en,
    output logic             alu_en,
    output logic             rf_we,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state_o
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
`endif
);

    if (!timeout_in_range(MEM_TIMEOUT) || (CNT_W < 1)) begin : g_bad_param
        $error("multicycle_sequencer: MEM_TIMEOUT must be 1..255 and CNT_W at least 1");
    end

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       w_run;
    logic       w_clear;
    logic       w_expired;
    logic       w_noop;
    logic       w_taken;

    assign w_noop  = ~(dec_halt | dec_jump | dec_jr | dec_jlink | dec_branch |
                       dec_blt | dec_load | dec_store | dec_wb);
    assign w_taken = dec_blt ? alu_neg : alu_zero;

    // Kept outside the FSM block so the timeout path has no combinational loop.
    assign mem_req = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_run   = mem_req & ~mem_ack;
    assign w_clear = (mem_req & mem_ack) | (w_next != r_state);

    seq_timeout_counter #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (w_run),
        .clear  (w_clear),
        .expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        w_next     = r_state;
        mem_we     = 1'b0;
        mem_sel_pc = 1'b0;
        ir_en      = 1'b0;
        ab_en      = 1'b0;
        alu_en     = 1'b0;
        rf_we      = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PC_INC;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_sel_pc = 1'b1;
                if (mem_ack) begin
                    ir_en  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_expired) begin
                    w_next = S_ERROR;
                end
            end
            S_DECODE: begin
                ab_en = 1'b1;
                if (dec_halt) begin
                    w_next = S_HALTED;
                end else if (dec_jr) begin
                    pc_en  = 1'b1;
                    pc_src = PC_REG;
                    w_next = S_FETCH;
                end else if (dec_jump && !dec_jlink) begin
                    pc_en  = 1'b1;
                    pc_src = PC_JMP;
                    w_next = S_FETCH;
                end else if (dec_jlink) begin
                    w_next = S_WB;
                end else if (w_noop) begin
                    pc_en  = 1'b1;
                    w_next = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (dec_branch) begin
                    pc_en  = 1'b1;
                    pc_src = w_taken ? PC_BR : PC_INC;
                    w_next = S_FETCH;
                end else if (dec_load || dec_store) begin
                    w_next = S_MEM;
                end else if (dec_wb) begin
                    w_next = S_WB;
                end else begin
                    // No result to keep: behave like a noop rather than stall.
                    pc_en  = 1'b1;
                    w_next = S_FETCH;
                end
            end
            S_MEM: begin
                mem_we = dec_store;
                if (mem_ack) begin
                    if (dec_load) begin
                        w_next = S_WB;
                    end else begin
                        pc_en  = 1'b1;
                        w_next = S_FETCH;
                    end
                end else if (w_expired) begin
                    w_next = S_ERROR;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_en  = 1'b1;
                pc_src = dec_jlink ? PC_JMP : PC_INC;
                w_next = S_FETCH;
            end
            S_HALTED: w_next = S_HALTED;
            S_ERROR:  w_next = S_ERROR;
        endcase
    end

    assign halted  = (r_state == S_HALTED);
    assign err     = (r_state == S_ERROR);
    assign state_o = r_state;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret;
    logic             w_active;
    logic             w_retire;

    assign w_active = (r_state != S_IDLE) && (r_state != S_HALTED) && (r_state != S_ERROR);
    assign w_retire = pc_en || ((r_state == S_DECODE) && (w_next == S_HALTED));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            if (w_active) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_retire) r_instret   <= r_instret + CNT_W'(1);
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instret   = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomised instruction stream checked cycle-by-cycle against a per-instruction
// expected-output model, plus directed timeout, halt and async-reset cases.
`timescale 1ns/1ps
module tb_multicycle_sequencer;

    localparam int TO = 15;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALTED = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    typedef enum int {I_ALU, I_LOAD, I_STORE, I_BEQ, I_BLT, I_J, I_JR, I_JL, I_NOOP, I_HALT} itype_t;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       selpc;
        logic       ir;
        logic       ab;
        logic       alu;
        logic       rf;
        logic       pc;
        logic [1:0] src;
        logic       hlt;
        logic       er;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic dec_halt = 1'b0, dec_jump = 1'b0, dec_jr = 1'b0, dec_jlink = 1'b0, dec_branch = 1'b0;
    logic dec_blt = 1'b0, dec_load = 1'b0, dec_store = 1'b0, dec_wb = 1'b0;
    logic alu_zero = 1'b0, alu_neg = 1'b0, mem_ack = 1'b0;
    logic mem_req, mem_we, mem_sel_pc, ir_en, ab_en, alu_en, rf_we, pc_en, halted, err;
    logic [1:0] pc_src;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dec_halt(dec_halt), .dec_jump(dec_jump), .dec_jr(dec_jr), .dec_jlink(dec_jlink),
        .dec_branch(dec_branch), .dec_blt(dec_blt), .dec_load(dec_load),
        .dec_store(dec_store), .dec_wb(dec_wb),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel_pc(mem_sel_pc), .ir_en(ir_en),
        .ab_en(ab_en), .alu_en(alu_en), .rf_we(rf_we), .pc_en(pc_en), .pc_src(pc_src),
        .halted(halted), .err(err), .state_o(state_o)
    );

    obs_t w_obs;
    assign w_obs = {state_o, mem_req, mem_we, mem_sel_pc, ir_en, ab_en, alu_en, rf_we,
                    pc_en, pc_src, halted, err};

    int   vectors = 0;
    int   errors  = 0;
    int   ncyc    = 0;
    int   cyc_no  = 0;
    obs_t q_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Single compare process: one expected record per cycle, sampled mid-cycle.
    always @(negedge clk) begin : cmp
        obs_t e;
        cyc_no++;
        if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            check($sformatf("cycle %0d (model state %0d)", cyc_no, e.st), {17'd0, w_obs}, {17'd0, e});
        end
    end

    function automatic obs_t rec(input logic [2:0] st);
        obs_t e;
        e     = '0;
        e.st  = st;
        e.hlt = (st == ST_HALTED);
        e.er  = (st == ST_ERROR);
        return e;
    endfunction

    function automatic logic noise();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input obs_t e, input logic ack);
        mem_ack = ack;
        q_exp.push_back(e);
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input itype_t t);
        {dec_halt, dec_jump, dec_jr, dec_jlink, dec_branch, dec_blt, dec_load, dec_store, dec_wb} = '0;
        case (t)
            I_ALU:   dec_wb = 1'b1;
            I_LOAD:  begin dec_load = 1'b1; dec_wb = 1'b1; end
            I_STORE: dec_store = 1'b1;
            I_BEQ:   dec_branch = 1'b1;
            I_BLT:   begin dec_branch = 1'b1; dec_blt = 1'b1; end
            I_J:     dec_jump = 1'b1;
            I_JR:    dec_jr = 1'b1;
            I_JL:    begin dec_jump = 1'b1; dec_jlink = 1'b1; dec_wb = 1'b1; end
            I_HALT:  dec_halt = 1'b1;
            default: ;
        endcase
    endtask

    // One instruction: lf = cycles until fetch ack, lm = cycles until data ack.
    task automatic run_instr(input itype_t t, input int lf, input int lm, input logic z, input logic n);
        obs_t e;
        logic taken;
        set_flags(t);
        alu_zero = z;
        alu_neg  = n;
        ncyc     = 0;
        for (int i = 1; i <= lf; i++) begin
            e = rec(ST_FETCH); e.req = 1'b1; e.selpc = 1'b1; e.ir = (i == lf);
            step(e, i == lf);
        end
        e = rec(ST_DECODE); e.ab = 1'b1;
        case (t)
            I_HALT: begin step(e, noise()); return; end
            I_JR:   begin e.pc = 1'b1; e.src = 2'b11; step(e, noise()); return; end
            I_J:    begin e.pc = 1'b1; e.src = 2'b01; step(e, noise()); return; end
            I_NOOP: begin e.pc = 1'b1; e.src = 2'b00; step(e, noise()); return; end
            I_JL: begin
                step(e, noise());
                e = rec(ST_WB); e.rf = 1'b1; e.pc = 1'b1; e.src = 2'b01;
                step(e, noise());
                return;
            end
            default: step(e, noise());
        endcase
        e = rec(ST_EXEC); e.alu = 1'b1;
        if (t == I_BEQ || t == I_BLT) begin
            taken = (t == I_BLT) ? n : z;
            e.pc  = 1'b1;
            e.src = taken ? 2'b10 : 2'b00;
            step(e, noise());
            return;
        end
        step(e, noise());
        if (t == I_LOAD || t == I_STORE) begin
            for (int i = 1; i <= lm; i++) begin
                e = rec(ST_MEM); e.req = 1'b1; e.we = (t == I_STORE);
                e.pc = (t == I_STORE) && (i == lm);
                step(e, i == lm);
            end
            if (t == I_STORE) return;
        end
        e = rec(ST_WB); e.rf = 1'b1; e.pc = 1'b1;
        step(e, noise());
    endtask

    // Fetch, decode and execute a memory instruction; returns at the first MEM cycle.
    task automatic to_mem(input itype_t t);
        obs_t e;
        set_flags(t);
        e = rec(ST_FETCH); e.req = 1'b1; e.selpc = 1'b1; e.ir = 1'b1;
        step(e, 1'b1);
        e = rec(ST_DECODE); e.ab = 1'b1;
        step(e, 1'b0);
        e = rec(ST_EXEC); e.alu = 1'b1;
        step(e, 1'b0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        mem_ack = 1'b0;
        set_flags(I_NOOP);
        #3;
        check("outputs during reset", {17'd0, w_obs}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_go();
        start = 1'b0;
        step(rec(ST_IDLE), noise());
        start = 1'b1;
        step(rec(ST_IDLE), noise());
    endtask

    initial begin
        obs_t e;
        itype_t t;
        int lf;
        int lm;

        do_reset();
        idle_go();

        run_instr(I_ALU, 1, 1, 1'b0, 1'b0);   check("add latency", ncyc, 4);
        run_instr(I_LOAD, 1, 3, 1'b0, 1'b0);  check("load 3-wait latency", ncyc, 7);
        run_instr(I_STORE, 1, 1, 1'b0, 1'b0); check("store latency", ncyc, 4);
        run_instr(I_BLT, 1, 1, 1'b0, 1'b1);   check("blt taken latency", ncyc, 3);
        run_instr(I_BLT, 1, 1, 1'b1, 1'b0);
        run_instr(I_BEQ, 1, 1, 1'b1, 1'b0);
        run_instr(I_J, 1, 1, 1'b0, 1'b0);     check("j latency", ncyc, 2);
        run_instr(I_JR, 1, 1, 1'b0, 1'b0);    check("jr latency", ncyc, 2);
        run_instr(I_NOOP, 1, 1, 1'b0, 1'b0);  check("noop latency", ncyc, 2);
        run_instr(I_JL, 1, 1, 1'b0, 1'b0);    check("jl latency", ncyc, 3);
        run_instr(I_ALU, TO, 1, 1'b0, 1'b0);  check("fetch ack on last allowed cycle", ncyc, TO + 3);
        run_instr(I_LOAD, 1, TO, 1'b0, 1'b0); check("data ack on last allowed cycle", ncyc, TO + 4);

        for (int k = 0; k < 250; k++) begin
            t  = itype_t'($urandom_range(0, 8));
            lf = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(1, 4));
            lm = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(1, 4));
            run_instr(t, lf, lm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        run_instr(I_HALT, 2, 1, 1'b0, 1'b0);  check("halt latency", ncyc, 3);
        for (int k = 0; k < 8; k++) begin
            start = 1'($urandom_range(0, 1));
            step(rec(ST_HALTED), noise());
        end

        // Fetch never acknowledged.
        do_reset();
        idle_go();
        set_flags(I_ALU);
        for (int i = 1; i <= TO; i++) begin
            e = rec(ST_FETCH); e.req = 1'b1; e.selpc = 1'b1;
            step(e, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            start = 1'($urandom_range(0, 1));
            step(rec(ST_ERROR), noise());
        end
        check("err/state/req after fetch timeout", {27'd0, err, state_o, mem_req}, {27'd0, 5'b11110});

        // Store never acknowledged.
        do_reset();
        idle_go();
        to_mem(I_STORE);
        for (int i = 1; i <= TO; i++) begin
            e = rec(ST_MEM); e.req = 1'b1; e.we = 1'b1;
            step(e, 1'b0);
        end
        for (int k = 0; k < 4; k++) step(rec(ST_ERROR), noise());

        // Asynchronous reset in the middle of a data access.
        do_reset();
        idle_go();
        to_mem(I_LOAD);
        mem_ack = 1'b0;
        #1;
        check("in MEM before async reset", {28'd0, state_o, mem_req}, {28'd0, 4'b1001});
        rst_n = 1'b0;
        #1;
        check("state/req right after async reset", {28'd0, state_o, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_go();
        run_instr(I_ALU, 1, 1, 1'b0, 1'b0);   check("add latency after reset", ncyc, 4);

        @(posedge clk);
        #1;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL expected-queue drain: %0d records left, expected 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM that sequences the 16-bit core's datapath one instruction at a time: fetch, decode, execute, memory, writeback. It consumes the decoder's per-instruction control flags and ALU flags. It owns the single shared memory port (instruction and data) through a req/ack handshake, and drives register, PC and RF enables. It sits between the instruction decoder and the datapath registers.

Parameters:
MEM_TIMEOUT, 15, cycles mem_req may stay high without mem_ack before the sequencer enters ERROR (1..255)
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; leaves IDLE when high
dec_halt, dec_jump, dec_jr, dec_jlink, dec_branch, dec_blt, dec_load, dec_store, dec_wb  in  1 each  decoder flags for the instruction in IR
alu_zero  in  1  ALU result == 0 (valid in EXEC)
alu_neg  in  1  ALU result sign bit (valid in EXEC)
mem_ack  in  1  memory completion; ignored unless mem_req high
mem_req  out  1  memory access request
mem_we  out  1  1 = write (store)
mem_sel_pc  out  1  1 = address from PC (fetch), 0 = ALU result
ir_en  out  1  load instruction register
ab_en  out  1  latch RF read operands
alu_en  out  1  latch ALU result
rf_we  out  1  register-file write
pc_en  out  1  update PC
pc_src  out  2  00 PC+1, 01 jump target, 10 branch target, 11 register (jr)
halted  out  1  in HALTED
err  out  1  in ERROR
state_o  out  3  current state encoding

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6, ERROR=7. Outputs are Moore on state plus mem_ack/dec_*/alu_* qualifiers. All outputs are combinational from registered state.
- Reset: state IDLE; every output 0 (pc_src=00). mem_req drops asynchronously mid-transaction; the timeout counter clears.
- IDLE: start=1 -> FETCH next cycle.
- FETCH: mem_req=1, mem_we=0, mem_sel_pc=1. Hold until mem_ack. In the ack cycle ir_en=1, next DECODE. Zero-wait ack (same cycle as req) is legal.
- DECODE: ab_en=1.
  - dec_halt -> HALTED; PC not advanced.
  - dec_jr -> pc_en, pc_src=11 -> FETCH.
  - dec_jump & !dec_jlink -> pc_en, pc_src=01 -> FETCH.
  - dec_jlink -> WB.
  - No flags set (noop) -> pc_en, pc_src=00 -> FETCH.
  - Otherwise -> EXEC.
- EXEC: alu_en=1.
  - dec_branch: taken = dec_blt ? alu_neg : alu_zero. pc_en=1, pc_src = taken ? 10 : 00 -> FETCH.
  - dec_load|dec_store -> MEM.
  - dec_wb -> WB.
- MEM: mem_req=1, mem_sel_pc=0, mem_we=dec_store. Wait for ack. On ack: load -> WB; store -> pc_en, pc_src=00 -> FETCH.
- WB: rf_we=1, pc_en=1, pc_src = dec_jlink ? 01 : 00 -> FETCH. The link value is taken from the un-updated PC in the same cycle.
- Latency with zero-wait memory: ALU op/addi/lui/slli 4, load 5, store 4, beq/blt 3, j/jr/noop 2, jl 3 cycles.
- Timeout: counter increments each cycle mem_req=1 & !mem_ack and clears on ack or state change. When the count reaches MEM_TIMEOUT -> ERROR. An ack in that same cycle wins, so no error is raised.
- HALTED and ERROR are terminal until reset; start is ignored in both. mem_req=0 in both.
- Decoder inputs must stay stable from DECODE until the return to FETCH, since IR is not rewritten.

Optional Feature:
SEQ_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[CNT_W-1:0] and instret[CNT_W-1:0].
  - cycle_cnt counts every cycle outside IDLE/HALTED/ERROR.
  - instret increments on every pc_en pulse and on entry to HALTED.
  - Both reset to 0 and wrap modulo 2^CNT_W.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package seq_pkg holds:
  - the state enum and its encodings;
  - the pc_src constants PC_INC, PC_JMP, PC_BR, PC_REG;
  - the MEM_TIMEOUT range check.
- One sub-module, seq_timeout_counter, with inputs clk, rst_n, run, clear and output expired.

Test Plan:
- add, zero-wait memory: start=1, ack same cycle -> states 1,2,3,5,1. rf_we for exactly one cycle in WB, with pc_en and pc_src=00 in that same cycle.
- load with 3-cycle data ack -> mem_req held 3 cycles with mem_sel_pc=0, mem_we=0. Then WB with rf_we=1. Total 7 cycles.
- blt with alu_neg=1 -> EXEC pc_src=10. Repeat with alu_neg=0, alu_zero=1 -> pc_src=00, not taken.
- jl -> DECODE, then WB with rf_we=1 and pc_src=01. jr -> pc_src=11 in DECODE, 2-cycle instruction.
- No mem_ack for 15 cycles during FETCH -> err=1, state_o=7, mem_req=0. Ack arriving on cycle 15 -> no error, DECODE.
- halt, then start toggling -> halted=1 persists, no pc_en. rst_n low mid-MEM -> mem_req falls before the next clk edge and state_o=0.
